// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the posted-store write buffer: depth default, drain states, lane mask.
package mem_write_buffer_pkg;

    localparam int         WB_DEPTH = 4;
    localparam logic [3:0] BE_WORD  = 4'hF;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

    function automatic logic is_full_word(input logic [3:0] be);
        return be == BE_WORD;
    endfunction

endpackage

// File: rtl/mem_write_buffer_if.sv
// Store, load-check and RAM drain signals of the write buffer bundled as one interface.
interface mem_write_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [3:0]    st_be;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ack;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ack,
        input  st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_wdata, mem_be, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, mem_ack,
        output st_ready, ld_hit, ld_data, ld_stall, mem_req, mem_addr, mem_wdata, mem_be, empty
    );

endinterface

// File: rtl/mem_write_buffer_wb_match.sv
// Address CAM over the buffered stores; the youngest matching entry decides forward vs stall.
module wb_match
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic [DEPTH-1:0][AW-1:0]      e_addr,
    input  logic [DEPTH-1:0][DW-1:0]      e_data,
    input  logic [DEPTH-1:0][3:0]         e_be,
    input  logic [DEPTH-1:0]              e_valid,
    input  logic [$clog2(DEPTH)-1:0]      tail,
    input  logic                          ld_valid,
    input  logic [AW-1:0]                 ld_addr,
    output logic                          hit,
    output logic                          stall,
    output logic [DW-1:0]                 data
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    logic          found;
    logic [PW-1:0] idx;
    logic [PW-1:0] sel;

    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (e_valid[idx] && (e_addr[idx] == (ld_addr & WORD_MASK))) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        hit   = ld_valid && found && is_full_word(e_be[sel]);
        stall = ld_valid && found && !is_full_word(e_be[sel]);
        data  = hit ? e_data[sel] : '0;
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO between the MEM stage and data RAM, drained by a req/ack FSM,
// with combinational load forwarding from buffered full-word stores.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic               clk,
    input logic               reset,
    mem_write_buffer_if.slave bus
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    logic [DEPTH-1:0][AW-1:0] e_addr;
    logic [DEPTH-1:0][DW-1:0] e_data;
    logic [DEPTH-1:0][3:0]    e_be;
    logic [DEPTH-1:0]         e_valid;

    logic [PW-1:0] head, tail, head_nxt;
    logic [PW:0]   count, count_nxt;
    logic          push, pop, take_st, load_mem;
    wb_state_t     state, state_nxt;

    assign bus.st_ready = count < (PW+1)'(DEPTH);
    assign bus.empty    = count == '0;
    assign push         = bus.st_valid && bus.st_ready && (bus.st_be != 4'b0000);
    assign pop          = bus.mem_req && bus.mem_ack;
    assign head_nxt     = head + PW'(pop);
    assign count_nxt    = count + (PW+1)'(push) - (PW+1)'(pop);
    // The incoming store becomes the next head only when nothing older remains after this edge.
    assign take_st      = push && ((count - (PW+1)'(pop)) == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= WB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: if ((count != '0) || push)     state_nxt = WB_REQ;
            WB_REQ:  if (pop && (count_nxt == '0))  state_nxt = WB_IDLE;
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req = (state == WB_REQ);
        load_mem    = (state_nxt == WB_REQ) && ((state == WB_IDLE) || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            head  <= head_nxt;
            count <= count_nxt;
            if (pop) e_valid[head] <= 1'b0;
            if (push) begin
                e_valid[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= bus.st_addr & WORD_MASK;
            e_data[tail] <= bus.st_data;
            e_be[tail]   <= bus.st_be;
        end
    end

    // Request fields are loaded once per entry and held until that entry is acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else if (load_mem) begin
            if (take_st) begin
                bus.mem_addr  <= bus.st_addr & WORD_MASK;
                bus.mem_wdata <= bus.st_data;
                bus.mem_be    <= bus.st_be;
            end else begin
                bus.mem_addr  <= e_addr[head_nxt];
                bus.mem_wdata <= e_data[head_nxt];
                bus.mem_be    <= e_be[head_nxt];
            end
        end
    end

    wb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .e_addr   (e_addr),
        .e_data   (e_data),
        .e_be     (e_be),
        .e_valid  (e_valid),
        .tail     (tail),
        .ld_valid (bus.ld_valid),
        .ld_addr  (bus.ld_addr),
        .hit      (bus.ld_hit),
        .stall    (bus.ld_stall),
        .data     (bus.ld_data)
    );

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed, table-driven bench for mem_write_buffer: per-cycle inputs with hand-computed outputs.
module tb_mem_write_buffer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_write_buffer_if #(.AW(32), .DW(32)) bus ();

    mem_write_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic [3:0]  sbe;
        logic        lv;
        logic [31:0] la;
        logic        ack;
        logic        rdy;
        logic        hit;
        logic [31:0] ldat;
        logic        stall;
        logic        req;
        logic        chkm;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  mbe;
        logic        empty;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    function automatic vec_t mkv(
        input logic rst, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
        input logic [3:0] sbe, input logic lv, input logic [31:0] la, input logic ack,
        input logic rdy, input logic hit, input logic [31:0] ldat, input logic stall,
        input logic req, input logic chkm, input logic [31:0] maddr, input logic [31:0] mwd,
        input logic [3:0] mbe, input logic empty);
        vec_t v;
        v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe;
        v.lv = lv; v.la = la; v.ack = ack;
        v.rdy = rdy; v.hit = hit; v.ldat = ldat; v.stall = stall; v.req = req;
        v.chkm = chkm; v.maddr = maddr; v.mwd = mwd; v.mbe = mbe; v.empty = empty;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then check the outputs before the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset        = v.rst;
        bus.st_valid = v.sv;
        bus.st_addr  = v.sa;
        bus.st_data  = v.sd;
        bus.st_be    = v.sbe;
        bus.ld_valid = v.lv;
        bus.ld_addr  = v.la;
        bus.mem_ack  = v.ack;
        #1;
        chk({tag, ".st_ready"}, 32'(bus.st_ready), 32'(v.rdy));
        chk({tag, ".ld_hit"},   32'(bus.ld_hit),   32'(v.hit));
        chk({tag, ".ld_data"},  bus.ld_data,       v.ldat);
        chk({tag, ".ld_stall"}, 32'(bus.ld_stall), 32'(v.stall));
        chk({tag, ".mem_req"},  32'(bus.mem_req),  32'(v.req));
        chk({tag, ".empty"},    32'(bus.empty),    32'(v.empty));
        if (v.chkm) begin
            chk({tag, ".mem_addr"},  bus.mem_addr,     v.maddr);
            chk({tag, ".mem_wdata"}, bus.mem_wdata,    v.mwd);
            chk({tag, ".mem_be"},    32'(bus.mem_be),  32'(v.mbe));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_be    = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
        repeat (2) @(posedge clk);

        //       rst sv sa     sd            sbe  lv la     ack | rdy hit ldat        stall req chkm maddr  mwd          mbe  empty
        // Reset state, single store drained with ack held high
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,0,32'h00,0, 1,0,32'h0,        0,0,1,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,1,32'h10,32'hDEADBEEF, 4'hF,0,32'h00,1, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h10,1, 1,1,32'hDEADBEEF, 0,1,1,32'h10,32'hDEADBEEF, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h10,1, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        // Fill with ack low, fifth store dropped, then drain one per cycle in order
        tbl.push_back(mkv(0,1,32'h40,32'hA1A1A1A1, 4'hF,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,1,32'h44,32'hA2A2A2A2, 4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h40,32'hA1A1A1A1, 4'hF,0));
        tbl.push_back(mkv(0,1,32'h48,32'hA3A3A3A3, 4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h40,32'hA1A1A1A1, 4'hF,0));
        tbl.push_back(mkv(0,1,32'h4C,32'hA4A4A4A4, 4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h40,32'hA1A1A1A1, 4'hF,0));
        tbl.push_back(mkv(0,1,32'h50,32'hA5A5A5A5, 4'hF,0,32'h00,0, 0,0,32'h0,        0,1,1,32'h40,32'hA1A1A1A1, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h50,1, 0,0,32'h0,        0,1,1,32'h40,32'hA1A1A1A1, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h44,32'hA2A2A2A2, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h48,32'hA3A3A3A3, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h4C,32'hA4A4A4A4, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,0,32'h00,1, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        // Two stores to one word: youngest forwards; same-cycle store is invisible
        tbl.push_back(mkv(0,1,32'h20,32'h11111111, 4'hF,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,1,32'h20,32'h22222222, 4'hF,1,32'h22,0, 1,1,32'h11111111, 0,1,1,32'h20,32'h11111111, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h22,0, 1,1,32'h22222222, 0,1,1,32'h20,32'h11111111, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h20,1, 1,1,32'h22222222, 0,1,1,32'h20,32'h11111111, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h20,1, 1,1,32'h22222222, 0,1,1,32'h20,32'h22222222, 4'hF,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h20,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        // Partial store stalls a matching load until its ack edge; be=0 is no store
        tbl.push_back(mkv(0,1,32'h30,32'h0000BEEF, 4'h3,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h30,0, 1,0,32'h0,        1,1,1,32'h30,32'h0000BEEF, 4'h3,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h30,0, 1,0,32'h0,        1,1,1,32'h30,32'h0000BEEF, 4'h3,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h30,1, 1,0,32'h0,        1,1,1,32'h30,32'h0000BEEF, 4'h3,0));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h30,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,1,32'h34,32'h12345678, 4'h0,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));
        tbl.push_back(mkv(0,0,32'h00,32'h0,        4'h0,1,32'h34,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

        // Full buffer: push refused during a pop, then push+pop with count 2 across the pointer wrap
        apply(mkv(0,1,32'h60,32'hB0B0B0B0,4'hF,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1), "full.s1");
        apply(mkv(0,1,32'h64,32'hB1B1B1B1,4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h60,32'hB0B0B0B0, 4'hF,0), "full.s2");
        apply(mkv(0,1,32'h68,32'hB2B2B2B2,4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h60,32'hB0B0B0B0, 4'hF,0), "full.s3");
        apply(mkv(0,1,32'h6D,32'hB3B3B3B3,4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h60,32'hB0B0B0B0, 4'hF,0), "full.s4");
        apply(mkv(0,1,32'h70,32'hB4B4B4B4,4'hF,0,32'h00,1, 0,0,32'h0,        0,1,1,32'h60,32'hB0B0B0B0, 4'hF,0), "full.s5");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,1,32'h70,0, 1,0,32'h0,        0,1,1,32'h64,32'hB1B1B1B1, 4'hF,0), "full.s6");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,1,32'h6C,1, 1,1,32'hB3B3B3B3, 0,1,1,32'h64,32'hB1B1B1B1, 4'hF,0), "full.s7");
        apply(mkv(0,1,32'h74,32'hB5B5B5B5,4'hF,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h68,32'hB2B2B2B2, 4'hF,0), "full.s8");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,1,32'h74,0, 1,1,32'hB5B5B5B5, 0,1,1,32'h6C,32'hB3B3B3B3, 4'hF,0), "full.s9");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h6C,32'hB3B3B3B3, 4'hF,0), "full.s10");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h74,32'hB5B5B5B5, 4'hF,0), "full.s11");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1), "full.s12");

        // Reset while requesting with three entries, then normal operation resumes
        apply(mkv(0,1,32'h80,32'hC0C0C0C0,4'hF,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1), "rst.r1");
        apply(mkv(0,1,32'h84,32'hC1C1C1C1,4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h80,32'hC0C0C0C0, 4'hF,0), "rst.r2");
        apply(mkv(0,1,32'h88,32'hC2C2C2C2,4'hF,0,32'h00,0, 1,0,32'h0,        0,1,1,32'h80,32'hC0C0C0C0, 4'hF,0), "rst.r3");
        apply(mkv(1,0,32'h00,32'h0,       4'h0,1,32'h84,0, 1,1,32'hC1C1C1C1, 0,1,1,32'h80,32'hC0C0C0C0, 4'hF,0), "rst.r4");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,1,32'h84,0, 1,0,32'h0,        0,0,1,32'h00,32'h0,        4'h0,1), "rst.r5");
        apply(mkv(0,1,32'h90,32'hC3C3C3C3,4'hF,0,32'h00,1, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1), "rst.r6");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,0,32'h00,1, 1,0,32'h0,        0,1,1,32'h90,32'hC3C3C3C3, 4'hF,0), "rst.r7");
        apply(mkv(0,0,32'h00,32'h0,       4'h0,0,32'h00,0, 1,0,32'h0,        0,0,0,32'h00,32'h0,        4'h0,1), "rst.r8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
